pong_game_ctrl: RTL and testbench

Match sequencer for the Pong design. It runs the game state machine (idle, serve, rally, point, game over) and keeps both players' scores. It also gates and re-centres the ball datapath from miss detection on the ball X coordinate. It sits beside the ball, racket and VGA blocks at top level, uses the VGA frame pulse as its time base, and drives the ball's enable/recentre controls plus the score values for on-screen rendering.

---
 rtl/pong_game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: game FSM, score keeping and ball gating/recentre.
// Optional build macro PONG_AUTO_RESTART_EN: OVER times out back to IDLE
// instead of waiting for start.
`timescale 1ns/1ps

module pong_game_ctrl #(
    parameter logic [9:0] MISS_LEFT    = 10'd30,
    parameter logic [9:0] MISS_RIGHT   = 10'd610,
    parameter logic [3:0] WIN_SCORE    = 4'd9,
    parameter logic [7:0] SERVE_FRAMES = 8'd60,
    parameter logic [7:0] POINT_FRAMES = 8'd30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] ball_x,
    output logic       ball_en,
    output logic       ball_recentre,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4
    } state_e;

`ifdef PONG_AUTO_RESTART_EN
    localparam int unsigned OverFramesRaw = 4 * int'(POINT_FRAMES);
    localparam logic [7:0]  OverFrames    = (OverFramesRaw > 255) ? 8'hFF : 8'(OverFramesRaw);
`endif

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0] winner_q, winner_d;
    logic       dir_q, dir_d;
    logic       recentre_q, recentre_d;
    logic       en_q, en_d;
    // armed_q: start has been seen low while waiting, so a high start is a fresh request
    logic       armed_q, armed_d;
    logic       begin_match;

    // Next-state, counter, score and output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        dir_d       = dir_q;
        recentre_d  = 1'b0;
        armed_d     = armed_q;
        begin_match = 1'b0;

        case (state_q)
            StIdle: begin
                armed_d = armed_q | ~start;
                if (start && armed_q) begin
                    begin_match = 1'b1;
                end
            end
            StServe: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = StPlay;
                    end
                end
            end
            StPlay: begin
                // Left miss has priority; ticks are irrelevant here
                if (ball_x <= MISS_LEFT) begin
                    if (p2_q < WIN_SCORE) p2_d = p2_q + 4'd1;
                    dir_d   = 1'b0;
                    cnt_d   = POINT_FRAMES;
                    state_d = StPoint;
                end else if (ball_x >= MISS_RIGHT) begin
                    if (p1_q < WIN_SCORE) p1_d = p1_q + 4'd1;
                    dir_d   = 1'b1;
                    cnt_d   = POINT_FRAMES;
                    state_d = StPoint;
                end
            end
            StPoint: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        if (p1_q == WIN_SCORE || p2_q == WIN_SCORE) begin
                            winner_d = (p1_q == WIN_SCORE) ? 2'b01 : 2'b10;
                            state_d  = StOver;
`ifdef PONG_AUTO_RESTART_EN
                            cnt_d    = OverFrames;
`endif
                        end else begin
                            recentre_d = 1'b1;
                            cnt_d      = SERVE_FRAMES;
                            state_d    = StServe;
                        end
                    end
                end
            end
            StOver: begin
`ifdef PONG_AUTO_RESTART_EN
                if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = StIdle;
                        armed_d = 1'b0;
                    end
                end
`else
                armed_d = armed_q | ~start;
                if (start && armed_q) begin
                    begin_match = 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        if (begin_match) begin
            p1_d       = 4'd0;
            p2_d       = 4'd0;
            winner_d   = 2'b00;
            dir_d      = 1'b1;
            recentre_d = 1'b1;
            cnt_d      = SERVE_FRAMES;
            state_d    = StServe;
            armed_d    = 1'b0;
        end

        en_d = (state_d == StPlay);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            p1_q       <= 4'd0;
            p2_q       <= 4'd0;
            winner_q   <= 2'b00;
            dir_q      <= 1'b1;
            recentre_q <= 1'b0;
            en_q       <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            winner_q   <= winner_d;
            dir_q      <= dir_d;
            recentre_q <= recentre_d;
            en_q       <= en_d;
            armed_q    <= armed_d;
        end
    end

    assign ball_en       = en_q;
    assign ball_recentre = recentre_q;
    assign serve_dir     = dir_q;
    assign score_p1      = p1_q;
    assign score_p2      = p2_q;
    assign winner        = winner_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: randomized rallies, misses and
// frame pacing checked against a point-level match model.
`timescale 1ns/1ps

module tb_pong_game_ctrl;

    localparam int Win   = 9;
    localparam int Serve = 60;
    localparam int Point = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] ball_x = 10'd320;
    logic       ball_en, ball_recentre, serve_dir;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Match model: scores, serve direction, winner
    int m_p1 = 0;
    int m_p2 = 0;
    int m_dir = 1;

    pong_game_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .start         (start),
        .ball_x        (ball_x),
        .ball_en       (ball_en),
        .ball_recentre (ball_recentre),
        .serve_dir     (serve_dir),
        .score_p1      (score_p1),
        .score_p2      (score_p2),
        .winner        (winner),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int exp_winner();
        if (m_p1 == Win) return 1;
        if (m_p2 == Win) return 2;
        return 0;
    endfunction

    // Issue n ticks with random gaps; state must hold st until the last one lands
    task automatic run_ticks(input string tag, input int n, input int st);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                if (int'(state) != st) bad++;
            end
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (i < n - 1 && int'(state) != st) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic begin_match();
        start = 1'b1;
        step();
        start = 1'b0;
        m_p1 = 0;
        m_p2 = 0;
        m_dir = 1;
        check("start_state", int'(state), 1);
        check("start_recentre", int'(ball_recentre), 1);
        check("start_scores", int'(score_p1) * 16 + int'(score_p2), 0);
        check("start_winner", int'(winner), 0);
        check("start_dir", int'(serve_dir), 1);
        step();
        check("recentre_width", int'(ball_recentre), 0);
        run_ticks("serve_hold", Serve, 1);
        check("serve_to_play", int'(state), 2);
        check("play_en", int'(ball_en), 1);
    endtask

    // One rally ending in a miss on the given side, then POINT and the follow-up
    task automatic play_point(input bit left);
        int bad = 0;
        int r;
        repeat ($urandom_range(1, 6)) begin
            r = $urandom_range(0, 3);
            ball_x = (r == 0) ? 10'd31 : (r == 1) ? 10'd609 : 10'($urandom_range(31, 609));
            frame_tick = 1'($urandom_range(0, 1));
            step();
            if (int'(state) != 2 || ball_en !== 1'b1) bad++;
        end
        check("rally_hold", bad, 0);
        r = $urandom_range(0, 3);
        if (left) ball_x = (r == 0) ? 10'd30 : 10'($urandom_range(0, 30));
        else      ball_x = (r == 0) ? 10'd610 : 10'($urandom_range(610, 1023));
        frame_tick = 1'($urandom_range(0, 1));
        step();
        frame_tick = 1'b0;
        ball_x = 10'd320;
        if (left) begin
            m_p2 = (m_p2 < Win) ? m_p2 + 1 : Win;
            m_dir = 0;
        end else begin
            m_p1 = (m_p1 < Win) ? m_p1 + 1 : Win;
            m_dir = 1;
        end
        check("miss_state", int'(state), 3);
        check("miss_en", int'(ball_en), 0);
        check("miss_p1", int'(score_p1), m_p1);
        check("miss_p2", int'(score_p2), m_p2);
        check("miss_dir", int'(serve_dir), m_dir);
        run_ticks("point_hold", Point, 3);
        if (exp_winner() != 0) begin
            check("over_state", int'(state), 4);
            check("over_winner", int'(winner), exp_winner());
        end else begin
            check("reserve_state", int'(state), 1);
            check("reserve_recentre", int'(ball_recentre), 1);
            step();
            check("reserve_width", int'(ball_recentre), 0);
            run_ticks("reserve_hold", Serve, 1);
            check("reserve_play", int'(state), 2);
        end
    endtask

    initial begin
        int bad;
        repeat (3) step();
        check("rst_state", int'(state), 0);
        check("rst_en", int'(ball_en), 0);
        check("rst_dir", int'(serve_dir), 1);
        check("rst_winner", int'(winner), 0);
        reset = 1'b1;
        repeat (2) step();
        check("idle_hold", int'(state), 0);
        begin_match();

        // Match 1: random sides until someone wins
        while (m_p1 < Win && m_p2 < Win) play_point(1'($urandom_range(0, 1)));

`ifdef PONG_AUTO_RESTART_EN
        run_ticks("over_hold", 4 * Point, 4);
        check("auto_idle", int'(state), 0);
        check("auto_keep_p1", int'(score_p1), m_p1);
        check("auto_keep_p2", int'(score_p2), m_p2);
        check("auto_keep_win", int'(winner), exp_winner());
        start = 1'b1;
        bad = 0;
        repeat (3) begin
            step();
            if (int'(state) != 0) bad++;
        end
        check("auto_start_edge", bad, 0);
        start = 1'b0;
        step();
`else
        run_ticks("over_hold", 20, 4);
        check("over_stay", int'(state), 4);
        check("over_keep_p1", int'(score_p1), m_p1);
        check("over_keep_p2", int'(score_p2), m_p2);
`endif
        begin_match();

        // Match 2: fixed 3/5 score then reset mid-rally
        for (int i = 0; i < 8; i++) play_point((i % 2 == 0) || (i >= 6));
        check("pre_rst_p1", int'(score_p1), 3);
        check("pre_rst_p2", int'(score_p2), 5);
        start = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_en", int'(ball_en), 0);
        check("async_recentre", int'(ball_recentre), 0);
        check("async_dir", int'(serve_dir), 1);
        check("async_scores", int'(score_p1) * 16 + int'(score_p2), 0);
        check("async_winner", int'(winner), 0);
        step();
        reset = 1'b1;
        bad = 0;
        repeat (4) begin
            step();
            if (int'(state) != 0 || ball_recentre !== 1'b0) bad++;
        end
        check("held_start_ignored", bad, 0);
        start = 1'b0;
        step();
        begin_match();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
